// File: rtl/xrek_registry_arbiter.sv
// Round-robin arbiter sharing one xrek capability registry between requesters.
// One registry op in flight at a time; result returned over valid/ready.
module xrek_registry_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int REG_DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ-1:0]     req_op,
  input  logic [NUM_REQ*256-1:0] req_name,
  input  logic [NUM_REQ*608-1:0] req_decl,
  output logic [NUM_REQ-1:0]     resp_valid,
  input  logic [NUM_REQ-1:0]     resp_ready,
  output logic [1:0]             resp_status,
  output logic [31:0]            resp_module,
  output logic [31:0]            resp_version,
  output logic [31:0]            resp_limits,
  output logic                   reg_declare_valid,
  output logic                   reg_query_valid,
  output logic [255:0]           reg_name,
  output logic [607:0]           reg_decl,
  input  logic [31:0]            reg_found_module,
  input  logic [31:0]            reg_found_version,
  input  logic [31:0]            reg_found_limits,
  input  logic                   reg_capability_found,
  input  logic [15:0]            reg_registered_count,
  input  logic                   reg_registry_ready,
  output logic                   busy,
  output logic [15:0]            reject_count
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [16:0] DEPTH = 17'(REG_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_ISSUE, S_WAIT, S_RESP
  } state_e;

  state_e              state_q;
  logic [IW-1:0]       ptr_q;
  logic [IW-1:0]       win_q;
  logic                op_q;
  logic [255:0]        name_q;
  logic [607:0]        decl_q;
  logic                decl_v_q;
  logic                query_v_q;
  logic [NUM_REQ-1:0]  resp_v_q;
  logic [1:0]          st_q;
  logic [31:0]         mod_q;
  logic [31:0]         ver_q;
  logic [31:0]         lim_q;
  logic [15:0]         rej_q;

  logic [255:0] name_a [NUM_REQ];
  logic [607:0] decl_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign name_a[g] = req_name[g*256 +: 256];
    assign decl_a[g] = req_decl[g*608 +: 608];
  end

  logic               hit_c;
  logic [IW-1:0]      win_c;
  logic [IW-1:0]      idx_c;
  logic [IW:0]        sum_c;
  logic [IW-1:0]      ptr_d;
  logic [NUM_REQ-1:0] grant_c;
  logic [NUM_REQ-1:0] win_oh;
  logic               full_c;

  // First valid requester at or after the pointer, wrapping
  always_comb begin
    hit_c = 1'b0;
    win_c = '0;
    idx_c = '0;
    sum_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum_c = {1'b0, ptr_q} + (IW+1)'(i);
      if (sum_c >= (IW+1)'(NUM_REQ))
        sum_c = sum_c - (IW+1)'(NUM_REQ);
      idx_c = sum_c[IW-1:0];
      if (!hit_c && req_valid[idx_c]) begin
        hit_c = 1'b1;
        win_c = idx_c;
      end
    end
  end

  always_comb begin
    grant_c = '0;
    if (state_q == S_ARB && hit_c)
      grant_c[win_c] = 1'b1;
    win_oh = '0;
    win_oh[win_q] = 1'b1;
  end

  assign ptr_d  = (win_c == IW'(NUM_REQ-1)) ? '0 : win_c + 1'b1;
  assign full_c = {1'b0, reg_registered_count} >= DEPTH;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      op_q      <= 1'b0;
      name_q    <= '0;
      decl_q    <= '0;
      decl_v_q  <= 1'b0;
      query_v_q <= 1'b0;
      resp_v_q  <= '0;
      st_q      <= '0;
      mod_q     <= '0;
      ver_q     <= '0;
      lim_q     <= '0;
      rej_q     <= '0;
    end else begin
      decl_v_q  <= 1'b0;
      query_v_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (reg_registry_ready && |req_valid)
            state_q <= S_ARB;
        end
        S_ARB: begin
          if (!hit_c) begin
            state_q <= S_IDLE;
          end else begin
            win_q <= win_c;
            ptr_q <= ptr_d;
            op_q  <= req_op[win_c];
            if (req_op[win_c] && full_c) begin
              // Full registry: answer locally, registry never sees it
              state_q  <= S_RESP;
              resp_v_q <= grant_c;
              st_q     <= 2'b10;
              mod_q    <= '0;
              ver_q    <= '0;
              lim_q    <= '0;
              if (rej_q != 16'hFFFF)
                rej_q <= rej_q + 16'd1;
            end else begin
              state_q   <= S_ISSUE;
              name_q    <= name_a[win_c];
              decl_q    <= decl_a[win_c];
              decl_v_q  <= req_op[win_c];
              query_v_q <= !req_op[win_c];
            end
          end
        end
        S_ISSUE: state_q <= S_WAIT;
        S_WAIT: begin
          state_q  <= S_RESP;
          resp_v_q <= win_oh;
          if (!op_q && reg_capability_found) begin
            st_q  <= 2'b00;
            mod_q <= reg_found_module;
            ver_q <= reg_found_version;
            lim_q <= reg_found_limits;
          end else begin
            st_q  <= op_q ? 2'b00 : 2'b01;
            mod_q <= '0;
            ver_q <= '0;
            lim_q <= '0;
          end
        end
        S_RESP: begin
          if (resp_ready[win_q]) begin
            resp_v_q <= '0;
            state_q  <= (|req_valid) ? S_ARB : S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready         = grant_c;
  assign resp_valid        = resp_v_q;
  assign resp_status       = st_q;
  assign resp_module       = mod_q;
  assign resp_version      = ver_q;
  assign resp_limits       = lim_q;
  assign reg_declare_valid = decl_v_q;
  assign reg_query_valid   = query_v_q;
  assign reg_name          = name_q;
  assign reg_decl          = decl_q;
  assign busy              = (state_q != S_IDLE);
  assign reject_count      = rej_q;

endmodule

// File: tb/tb_xrek_registry_arbiter.sv
// Directed bench for xrek_registry_arbiter: vector table plus
// hand-written backpressure, reset-abort and round-robin sequences.
module tb_xrek_registry_arbiter;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [3:0]    req_op;
  logic [1023:0] req_name;
  logic [2431:0] req_decl;
  logic [3:0]    resp_valid;
  logic [3:0]    resp_ready;
  logic [1:0]    resp_status;
  logic [31:0]   resp_module, resp_version, resp_limits;
  logic          reg_declare_valid, reg_query_valid;
  logic [255:0]  reg_name;
  logic [607:0]  reg_decl;
  logic [31:0]   reg_found_module, reg_found_version, reg_found_limits;
  logic          reg_capability_found;
  logic [15:0]   reg_registered_count;
  logic          reg_registry_ready;
  logic          busy;
  logic [15:0]   reject_count;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  xrek_registry_arbiter #(.NUM_REQ(4), .REG_DEPTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_name(req_name), .req_decl(req_decl),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_status(resp_status), .resp_module(resp_module),
    .resp_version(resp_version), .resp_limits(resp_limits),
    .reg_declare_valid(reg_declare_valid),
    .reg_query_valid(reg_query_valid),
    .reg_name(reg_name), .reg_decl(reg_decl),
    .reg_found_module(reg_found_module),
    .reg_found_version(reg_found_version),
    .reg_found_limits(reg_found_limits),
    .reg_capability_found(reg_capability_found),
    .reg_registered_count(reg_registered_count),
    .reg_registry_ready(reg_registry_ready),
    .busy(busy), .reject_count(reject_count)
  );

  typedef struct {
    int           r;
    bit           op;
    logic [255:0] name;
    logic [607:0] decl;
    bit           found;
    logic [31:0]  fm, fv, fl;
    logic [15:0]  cnt;
    logic [1:0]   st;
    logic [31:0]  em, ev, el;
    int           lat;
  } vec_t;

  function automatic logic [3:0] onehot(int r);
    return 4'b0001 << r;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_grant(int r, string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == 4'b0 && n < 20);
    chk(nm, 64'(req_ready), 64'(onehot(r)));
  endtask

  task automatic drop(int r);
    @(posedge clk);
    #1 req_valid[r] = 1'b0;
  endtask

  task automatic wait_resp(int r, string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (resp_valid == 4'b0 && n < 20);
    chk(nm, 64'(resp_valid), 64'(onehot(r)));
  endtask

  task automatic ack(int r);
    resp_ready[r] = 1'b1;
    @(posedge clk);
    #1 resp_ready[r] = 1'b0;
  endtask

  task automatic set_reg(bit f, logic [31:0] m, logic [31:0] v,
                         logic [31:0] l, logic [15:0] c);
    reg_capability_found = f;
    reg_found_module     = m;
    reg_found_version    = v;
    reg_found_limits     = l;
    reg_registered_count = c;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int rk, pk, nq, nd;
    rk = 0; pk = 0; nq = 0; nd = 0;
    set_reg(v.found, v.fm, v.fv, v.fl, v.cnt);
    req_op[v.r] = v.op;
    req_name[v.r*256 +: 256] = v.name;
    req_decl[v.r*608 +: 608] = v.decl;
    req_valid[v.r] = 1'b1;
    wait_grant(v.r, $sformatf("v%0d_grant", id));
    drop(v.r);
    for (int k = 1; k <= 8 && rk == 0; k++) begin
      @(negedge clk);
      if (reg_query_valid) begin nq++; pk = k; end
      if (reg_declare_valid) begin
        nd++; pk = k;
        chk($sformatf("v%0d_reg_decl", id), 64'(reg_decl == v.decl), 1);
      end
      if (reg_query_valid || reg_declare_valid)
        chk($sformatf("v%0d_reg_name", id), 64'(reg_name == v.name), 1);
      if (resp_valid != 4'b0) rk = k;
    end
    chk($sformatf("v%0d_latency", id), 64'(rk), 64'(v.lat));
    chk($sformatf("v%0d_query_pulses", id), 64'(nq),
        (v.lat == 3 && !v.op) ? 64'd1 : 64'd0);
    chk($sformatf("v%0d_decl_pulses", id), 64'(nd),
        (v.lat == 3 && v.op) ? 64'd1 : 64'd0);
    if (v.lat == 3)
      chk($sformatf("v%0d_pulse_cycle", id), 64'(pk), 64'd1);
    chk($sformatf("v%0d_resp_valid", id), 64'(resp_valid), 64'(onehot(v.r)));
    chk($sformatf("v%0d_status", id), 64'(resp_status), 64'(v.st));
    chk($sformatf("v%0d_module", id), 64'(resp_module), 64'(v.em));
    chk($sformatf("v%0d_version", id), 64'(resp_version), 64'(v.ev));
    chk($sformatf("v%0d_limits", id), 64'(resp_limits), 64'(v.el));
    ack(v.r);
    @(negedge clk);
    chk($sformatf("v%0d_resp_drop", id), 64'(resp_valid), 64'd0);
  endtask

  vec_t        vt[6];
  logic [607:0] d0;
  int          exp_o[5] = '{0, 1, 2, 3, 0};

  initial begin
    d0 = {32'h0000_0011, 32'h0000_0002, {8{32'hC0FF_EE00}},
          32'h0000_0055, {8{32'hDEAD_BEEF}}};
    vt[0] = '{r:0, op:0, name:256'h41, decl:'0, found:1,
              fm:32'h11, fv:32'h2, fl:32'h55, cnt:16'd1,
              st:2'b00, em:32'h11, ev:32'h2, el:32'h55, lat:3};
    vt[1] = '{r:1, op:0, name:256'h5A, decl:'0, found:0,
              fm:32'h99, fv:32'h9, fl:32'h9, cnt:16'd1,
              st:2'b01, em:32'h0, ev:32'h0, el:32'h0, lat:3};
    vt[2] = '{r:3, op:1, name:256'h42, decl:d0, found:1,
              fm:32'h77, fv:32'h7, fl:32'h7, cnt:16'd31,
              st:2'b00, em:32'h0, ev:32'h0, el:32'h0, lat:3};
    vt[3] = '{r:2, op:1, name:256'h43, decl:d0, found:1,
              fm:32'h77, fv:32'h7, fl:32'h7, cnt:16'd32,
              st:2'b10, em:32'h0, ev:32'h0, el:32'h0, lat:1};
    vt[4] = '{r:2, op:0, name:256'h41, decl:'0, found:1,
              fm:32'hAB, fv:32'hCD, fl:32'hEF, cnt:16'd40,
              st:2'b00, em:32'hAB, ev:32'hCD, el:32'hEF, lat:3};
    vt[5] = '{r:0, op:1, name:256'h44, decl:d0, found:0,
              fm:32'h0, fv:32'h0, fl:32'h0, cnt:16'd33,
              st:2'b10, em:32'h0, ev:32'h0, el:32'h0, lat:1};

    rst = 1'b1;
    req_valid = '0; req_op = '0; req_name = '0; req_decl = '0;
    resp_ready = '0;
    reg_registry_ready = 1'b1;
    set_reg(1'b0, '0, '0, '0, '0);
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", 64'(resp_valid), 0);
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_reg_strobes", 64'({reg_declare_valid, reg_query_valid}), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_reject_count", 64'(reject_count), 0);
    chk("rst_reg_name", 64'(reg_name != '0), 0);
    chk("rst_status", 64'(resp_status), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vt[i], i);
    chk("reject_count_after_table", 64'(reject_count), 2);

    // Backpressure: response held for 10 cycles with R0 pending
    set_reg(1'b1, 32'h31, 32'h32, 32'h33, 16'd0);
    req_op[1] = 1'b0;
    req_valid[1] = 1'b1;
    wait_grant(1, "bp_grant");
    drop(1);
    wait_resp(1, "bp_resp");
    req_op[0] = 1'b0;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(resp_valid), 64'(onehot(1)));
      chk("bp_hold_module", 64'(resp_module), 64'h31);
      chk("bp_no_ready", 64'(req_ready), 0);
      chk("bp_busy", 64'(busy), 1);
    end
    ack(1);
    wait_grant(0, "bp_next_grant");
    drop(0);
    wait_resp(0, "bp_next_resp");
    ack(0);

    // Reset asserted while the query sits in WAIT
    req_op[2] = 1'b0;
    req_valid[2] = 1'b1;
    wait_grant(2, "ra_grant");
    drop(2);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ra_busy", 64'(busy), 0);
    chk("ra_resp_valid", 64'(resp_valid), 0);
    chk("ra_req_ready", 64'(req_ready), 0);
    chk("ra_reg_strobes", 64'({reg_declare_valid, reg_query_valid}), 0);
    chk("ra_reject_count", 64'(reject_count), 0);
    chk("ra_reg_name", 64'(reg_name != '0), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ra_no_resp", 64'(resp_valid), 0);
    end
    set_reg(1'b1, 32'h41, 32'h42, 32'h43, 16'd0);
    req_op[0] = 1'b0;
    req_op[3] = 1'b0;
    req_valid[0] = 1'b1;
    req_valid[3] = 1'b1;
    wait_grant(0, "ra_ptr_grant");
    drop(0);
    wait_resp(0, "ra_after_resp");
    chk("ra_after_module", 64'(resp_module), 64'h41);
    chk("ra_after_status", 64'(resp_status), 0);
    ack(0);
    wait_grant(3, "ra_second_grant");
    drop(3);
    wait_resp(3, "ra_second_resp");
    ack(3);

    // Round robin: all four at once, R0 stays asserted
    resp_ready = 4'hF;
    req_op = 4'h0;
    req_valid = 4'hF;
    for (int g = 0; g < 5; g++) begin
      wait_grant(exp_o[g], $sformatf("rr_grant%0d", g));
      @(posedge clk);
      #1;
      if (g != 0) req_valid[exp_o[g]] = 1'b0;
    end
    req_valid = '0;
    repeat (8) @(negedge clk);
    chk("rr_idle_busy", 64'(busy), 0);
    chk("rr_idle_resp", 64'(resp_valid), 0);
    resp_ready = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/xrek_registry_arbiter.md
Name: xrek_registry_arbiter

Overview:
- Shares one xrek capability registry between NUM_REQ requesters.
- Round-robin arbitration over declare and query requests; issues exactly one registry operation at a time.
- Captures the registry result and returns it to the granted requester over a valid/ready response handshake.
- Sits between the module-manager agents and the registry; no requester drives the registry directly.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
REG_DEPTH, 32, registry capacity; declares at this count are rejected locally

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  one-hot accept pulse
req_op  in  NUM_REQ  1=declare, 0=query
req_name  in  NUM_REQ*256  capability name (declare name / query key)
req_decl  in  NUM_REQ*608  {module_id32, version32, constraints256, limits32, deps256}
resp_valid  out  NUM_REQ  one-hot response valid
resp_ready  in  NUM_REQ  per-requester response ready
resp_status  out  2  00 ok/found, 01 not found, 10 rejected-full
resp_module  out  32  found module id (query), else 0
resp_version  out  32  found version (query), else 0
resp_limits  out  32  found usage limits (query), else 0
reg_declare_valid  out  1  registry declare strobe
reg_query_valid  out  1  registry query strobe
reg_name  out  256  capability_name / query_capability to registry
reg_decl  out  608  declare fields to registry, same packing
reg_found_module, reg_found_version, reg_found_limits  in  32 each  registry results
reg_capability_found  in  1  registry found flag
reg_registered_count  in  16  registry entry count
reg_registry_ready  in  1  registry ready
busy  out  1  high in every state except IDLE
reject_count  out  16  saturating count of rejected-full declares

Behaviour:
- Reset: all outputs 0, FSM=IDLE, RR pointer=0, latched payload=0. Asynchronous reset mid-operation aborts the in-flight op; no response is produced for it.
- FSM states: IDLE, ARB, ISSUE, WAIT, RESP.
- IDLE -> ARB when reg_registry_ready=1 and any req_valid.
- ARB (1 cycle):
  - Winner is the first req_valid at or after RR pointer, wrapping modulo NUM_REQ.
  - req_ready[winner]=1 for this cycle only; latch op, name, decl and winner index.
  - RR pointer <= winner+1 (wraps to 0).
  - If no req_valid remains, return to IDLE.
- Rejected-full path (bypasses ISSUE/WAIT): declare with reg_registered_count >= REG_DEPTH at ARB:
  - Go directly to RESP with status 10 and zero data.
  - reject_count increments; holds at 0xFFFF.
- ISSUE (1 cycle):
  - Drive reg_name and reg_decl from latched values.
  - Pulse reg_declare_valid or reg_query_valid (never both, never longer than 1 cycle).
- WAIT (1 cycle): registry outputs are valid; capture them at the end of this cycle.
  - Query: status = found ? 00 : 01; data = found fields, else 0.
  - Declare: status 00, data 0.
- RESP:
  - resp_valid[winner]=1, other bits 0; data held stable.
  - Exit on resp_ready[winner]: resp_valid deasserts next cycle.
  - Next state is ARB if any req_valid, else IDLE.
- Latency: ARB accept at cycle T -> ISSUE T+1 -> WAIT T+2 -> resp_valid from T+3. Rejected declare: resp_valid from T+1.
- reg_name and reg_decl hold their last values outside ISSUE.
- At most one op is outstanding. A requester's own re-request is not considered until its response completes.
- req_valid deasserted before req_ready is legal; that requester is simply not granted.
- reg_registry_ready=0 is only checked in IDLE.
- busy stays high through RESP backpressure of any length.

Test Plan:
- Single query, R0 name "A" registered by module 0x11, version 0x2 -> reg_query_valid 1 cycle at T+1; resp_valid[0] at T+3; status 00; module 0x11; version 0x2.
- Query unknown name -> status 01, module/version/limits 0.
- All four requesters assert together, pointer=0 -> grants in order R0, R1, R2, R3. R0 re-asserts -> granted only after R3 (pointer wrap).
- Registry reports count 32, R2 declares -> no reg_declare_valid pulse; resp_valid[2] at T+1 with status 10; reject_count 0 -> 1.
- resp_ready held low 10 cycles -> resp_valid and data stable; no new req_ready; busy=1 throughout.
- Assert rst during WAIT -> all outputs 0 immediately; FSM IDLE; pointer 0; a new request afterwards completes normally.
